// File: rtl/adpcm_pkg.sv
// Shared ADPCM datapath constants: widths, rate codes,
// scale factor limits/reset values and the FUNCTW tables.
package adpcm_pkg;

  localparam int YU_W = 13;
  localparam int YL_W = 19;
  localparam int WI_W = 12;

  localparam logic [1:0] RATE_16 = 2'b11;
  localparam logic [1:0] RATE_24 = 2'b10;
  localparam logic [1:0] RATE_32 = 2'b01;
  localparam logic [1:0] RATE_40 = 2'b00;

  localparam logic [YU_W-1:0] YU_MIN = 13'd544;
  localparam logic [YU_W-1:0] YU_MAX = 13'd5120;

  localparam logic [YU_W-1:0] RESET_YU_DEF = 13'd544;
  localparam logic [YL_W-1:0] RESET_YL_DEF = 19'd34816;

  localparam logic [WI_W-1:0] WI_40 [16] = '{
    12'd14,  12'd14,  12'd24,  12'd39,
    12'd40,  12'd41,  12'd58,  12'd100,
    12'd141, 12'd179, 12'd219, 12'd280,
    12'd358, 12'd440, 12'd529, 12'd696
  };

  localparam logic [WI_W-1:0] WI_32 [8] = '{
    12'd4084, 12'd18,  12'd41,  12'd64,
    12'd112,  12'd198, 12'd355, 12'd1122
  };

  localparam logic [WI_W-1:0] WI_24 [4] = '{
    12'd4092, 12'd30, 12'd137, 12'd582
  };

  localparam logic [WI_W-1:0] WI_16 [2] = '{
    12'd4074, 12'd439
  };

  // Negative codes mirror: (2^n-1-I) on the low bits is just ~I.
  function automatic logic [WI_W-1:0] functw(
    input logic [1:0] rate,
    input logic [4:0] code
  );
    logic [WI_W-1:0] wi;
    wi = '0;
    unique case (rate)
      RATE_40: wi = WI_40[code[4] ? ~code[3:0] : code[3:0]];
      RATE_32: wi = WI_32[code[3] ? ~code[2:0] : code[2:0]];
      RATE_24: wi = WI_24[code[2] ? ~code[1:0] : code[1:0]];
      RATE_16: wi = WI_16[code[1] ? ~code[0] : code[0]];
    endcase
    return wi;
  endfunction

endpackage

// File: rtl/DELAY.sv
// Generic registered delay element with a
// parameterised synchronous reset value.
module DELAY #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_STATE;
    else       q <= d;
  end

endmodule

// File: rtl/scale_mix.sv
// MIX stage: blends fast and slow scale factors
// under speed control AL (64 = 1.0).
module scale_mix
  import adpcm_pkg::*;
(
  input  logic [YU_W-1:0] yu,
  input  logic [YL_W-1:0] yl,
  input  logic [6:0]      al,
  output logic [YU_W-1:0] y
);

  logic [YU_W-1:0] yls;
  logic [YU_W:0]   dif;
  logic            neg;
  logic [YU_W-1:0] mag;
  logic [19:0]     prod_full;
  logic [YU_W:0]   prod;

  assign yls = 13'(yl >> 6);
  assign dif = {1'b0, yu} - {1'b0, yls};
  assign neg = dif[YU_W];
  assign mag = neg ? 13'(-dif) : dif[YU_W-1:0];

  // Sign/magnitude product so the shift truncates toward zero.
  assign prod_full = 20'(mag) * 20'(al);
  assign prod      = 14'(prod_full >> 6);

  assign y = neg ? 13'({1'b0, yls} - prod)
                 : 13'({1'b0, yls} + prod);

endmodule

// File: rtl/scale_fac_adapt.sv
// Quantizer scale factor adaptation: FUNCTW, FILTD,
// LIMB, FILTE and MIX around the YU/YL registers.
module scale_fac_adapt
  import adpcm_pkg::*;
#(
  parameter logic [YU_W-1:0] RESET_YU = RESET_YU_DEF,
  parameter logic [YL_W-1:0] RESET_YL = RESET_YL_DEF
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [1:0]      RATE,
  input  logic [4:0]      I,
  input  logic [6:0]      AL,
  output logic [YU_W-1:0] Y,
  output logic [YL_W-1:0] YL,
  input  logic            scan_enable,
  input  logic            scan_in0,
  input  logic            scan_in1,
  input  logic            scan_in2,
  input  logic            scan_in3,
  input  logic            scan_in4,
  output logic            scan_out0,
  output logic            scan_out1,
  output logic            scan_out2,
  output logic            scan_out3,
  output logic            scan_out4
);

  logic [YU_W-1:0] yu;
  logic [YU_W-1:0] yut;
  logic [YU_W-1:0] yup;
  logic [YU_W-1:0] y;
  logic [YL_W-1:0] yl;
  logic [YL_W-1:0] ylp;
  logic [WI_W-1:0] wi;
  logic [16:0]     dif_d;
  logic [16:0]     difsx_d;
  logic [19:0]     yl_neg;
  logic [13:0]     dif_e;

  assign wi = functw(RATE, I);

  // FILTD: modular 17-bit difference, arithmetic >>5.
  assign dif_d   = {wi, 5'd0} - {4'd0, y};
  assign difsx_d = 17'($signed(dif_d) >>> 5);
  assign yut     = 13'(difsx_d + {4'd0, y});

  always_comb begin
    yup = yut;
    if (yut < YU_MIN)      yup = YU_MIN;
    else if (yut > YU_MAX) yup = YU_MAX;
  end

  // FILTE: 20-bit negate then >>6 matches (2^20-YL)>>6.
  assign yl_neg = 20'd0 - {1'b0, yl};
  assign dif_e  = {1'b0, yup} + 14'(yl_neg >> 6);
  assign ylp    = yl + {{5{dif_e[13]}}, dif_e};

  DELAY #(
    .WIDTH       (YU_W),
    .RESET_STATE (RESET_YU)
  ) u_yu (
    .clk   (CLK),
    .reset (reset),
    .d     (yup),
    .q     (yu)
  );

  DELAY #(
    .WIDTH       (YL_W),
    .RESET_STATE (RESET_YL)
  ) u_yl (
    .clk   (CLK),
    .reset (reset),
    .d     (ylp),
    .q     (yl)
  );

  scale_mix u_mix (
    .yu (yu),
    .yl (yl),
    .al (AL),
    .y  (y)
  );

  assign Y  = y;
  assign YL = yl;

  assign scan_out0 = scan_enable & scan_in0;
  assign scan_out1 = scan_enable & scan_in1;
  assign scan_out2 = scan_enable & scan_in2;
  assign scan_out3 = scan_enable & scan_in3;
  assign scan_out4 = scan_enable & scan_in4;

endmodule

// File: tb/tb_scale_fac_adapt.sv
// Bench for scale_fac_adapt: integer reference model
// checked every cycle plus hand-computed expectations.
module tb_scale_fac_adapt;

  logic        CLK = 1'b0;
  logic        reset;
  logic [1:0]  RATE;
  logic [4:0]  I;
  logic [6:0]  AL;
  logic [12:0] Y;
  logic [18:0] YL;
  logic        scan_enable;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int n_checks = 0;
  int n_pass   = 0;
  int m_yu;
  int m_yl;
  bit model_ok = 1'b0;

  int t40 [16] = '{14, 14, 24, 39, 40, 41, 58, 100,
                   141, 179, 219, 280, 358, 440, 529, 696};
  int t32 [8]  = '{4084, 18, 41, 64, 112, 198, 355, 1122};
  int t24 [4]  = '{4092, 30, 137, 582};
  int t16 [2]  = '{4074, 439};

  scale_fac_adapt dut (
    .CLK         (CLK),
    .reset       (reset),
    .RATE        (RATE),
    .I           (I),
    .AL          (AL),
    .Y           (Y),
    .YL          (YL),
    .scan_enable (scan_enable),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int wi_of(input int rate, input int code);
    int n, c, s, im;
    n  = (rate == 0) ? 5 : (rate == 1) ? 4 : (rate == 2) ? 3 : 2;
    c  = code & ((1 << n) - 1);
    s  = (c >> (n - 1)) & 1;
    im = s ? (((1 << n) - 1 - c) & ((1 << (n - 1)) - 1)) : c;
    case (n)
      5:       return t40[im];
      4:       return t32[im];
      3:       return t24[im];
      default: return t16[im];
    endcase
  endfunction

  function automatic int mix(input int yu, input int yl, input int al);
    int yls, d, p;
    yls = yl >> 6;
    d   = yu - yls;
    p   = (((d < 0) ? -d : d) * al) >> 6;
    return (yls + ((d < 0) ? -p : p)) & 8191;
  endfunction

  task automatic next_state(input int yu, input int yl, input int rate,
                            input int code, input int al,
                            output int nyu, output int nyl);
    int y, dif, dsx, yut, yup;
    y   = mix(yu, yl, al);
    dif = ((wi_of(rate, code) << 5) + 131072 - y) & 131071;
    dsx = dif[16] ? (dif >> 5) + 126976 : dif >> 5;
    yut = (y + dsx) & 8191;
    yup = (yut < 544) ? 544 : (yut > 5120) ? 5120 : yut;
    dif = (yup + ((1048576 - yl) >> 6)) & 16383;
    dsx = dif[13] ? dif + 507904 : dif;
    nyu = yup;
    nyl = (yl + dsx) & 524287;
  endtask

  always @(posedge CLK) begin
    int nyu, nyl;
    if (reset) begin
      m_yu     <= 544;
      m_yl     <= 34816;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      next_state(m_yu, m_yl, int'(RATE), int'(I), int'(AL), nyu, nyl);
      m_yu <= nyu;
      m_yl <= nyl;
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      check("model_y", int'(Y), mix(m_yu, m_yl, int'(AL)));
      check("model_yl", int'(YL), m_yl);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int prev;
    reset       = 1'b1;
    RATE        = 2'b01;
    I           = 5'd0;
    AL          = 7'd0;
    scan_enable = 1'b0;
    scan_in0    = 1'b0;
    scan_in1    = 1'b0;
    scan_in2    = 1'b0;
    scan_in3    = 1'b0;
    scan_in4    = 1'b0;
    tick();
    tick();
    check("rst_y_al0", int'(Y), 544);
    check("rst_yl", int'(YL), 34816);
    AL = 7'd64;
    #1;
    check("rst_y_al64", int'(Y), 544);

    reset = 1'b0;
    I     = 5'd7;
    tick();
    check("r32_step_y", int'(Y), 1649);
    check("r32_step_yl", int'(YL), 35921);
    AL = 7'd0;
    #1;
    check("r32_step_y_al0", int'(Y), 561);
    AL = 7'd64;

    restart();
    I = 5'd8;
    tick();
    check("r32_mirror_y", int'(Y), 1649);
    check("r32_mirror_yl", int'(YL), 35921);

    restart();
    RATE = 2'b10;
    I    = 5'd3;
    tick();
    check("r24_y", int'(Y), 1109);

    restart();
    RATE = 2'b11;
    I    = 5'd1;
    tick();
    check("r16_y", int'(Y), 966);
    restart();
    I = 5'd2;
    tick();
    check("r16_mirror_y", int'(Y), 966);

    restart();
    RATE = 2'b00;
    I    = 5'd15;
    tick();
    check("r40_y", int'(Y), 1223);

    restart();
    RATE = 2'b01;
    I    = 5'd0;
    tick();
    check("lo_clamp_first", int'(Y), 544);
    repeat (99) tick();
    check("lo_clamp_hold", int'(Y), 544);

    restart();
    I    = 5'd7;
    prev = 34816;
    for (int k = 0; k < 500; k++) begin
      tick();
      check("hi_clamp_bound", int'(Y <= 13'd5120), 1);
      check("hi_yl_mono", int'(int'(YL) >= prev), 1);
      prev = int'(YL);
    end
    check("hi_clamp_sat", int'(Y), 5120);

    restart();
    I = 5'd7;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_y", int'(Y), 544);
    check("mid_rst_yl", int'(YL), 34816);
    reset = 1'b0;
    tick();
    check("mid_resume_y", int'(Y), 1649);
    check("mid_resume_yl", int'(YL), 35921);

    for (int r = 0; r < 4; r++) begin
      restart();
      RATE = 2'(r);
      for (int c = 0; c < 32; c++) begin
        I  = 5'((c * 7 + r) % 32);
        AL = 7'((c * 13 + r * 29) % 128);
        tick();
      end
    end

    AL = 7'd127;
    RATE = 2'b01;
    I = 5'd9;
    repeat (20) tick();
    I = 5'd2;
    repeat (20) tick();

    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scale_fac_adapt.md
# scale_fac_adapt

Quantizer scale factor adaptation stage of the ADPCM codec: computes the fast (YU) and slow (YL) scale factors from the current ADPCM code and mixes them under the speed control parameter AL into the scale factor Y. It sits directly downstream of ADAP_SPED_CTL, which consumes its Y output and feeds its AL input. Y also drives the quantizer and inverse quantizer. YL is exported for transition detection (TR generation). One sample per CLK cycle, as in the rest of the datapath.

## Interface
- RESET_YU, 544: fast scale factor reset value (13-bit).
- RESET_YL, 34816: slow scale factor reset value (19-bit).
- CLK  in  1  sample clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RATE  in  2  rate select: 11 = 16 kbit/s, 10 = 24, 01 = 32, 00 = 40.
- I  in  5  ADPCM codeword, right-justified; width used per RATE (2/3/4/5 bits).
- AL  in  7  speed control from ADAP_SPED_CTL, unsigned, 64 = 1.0.
- Y  out  13  mixed scale factor, unsigned.
- YL  out  19  slow scale factor register, unsigned.
- scan_enable, scan_in0..scan_in4  in  1 each  scan chain inputs, left unconnected functionally.
- scan_out0..scan_out4  out  1 each  scan chain outputs.

## Operation
- **FUNCTW:** map I to WI (12-bit two's complement, already scaled by 2^-5).
  - Sign IS = MSB of the active code width.
  - Magnitude index: IM = IS ? (2^n−1−I) & (2^(n−1)−1) : I.
  - 32k table, IM 0..7: 4084, 18, 41, 64, 112, 198, 355, 1122.
  - 24k table, IM 0..3: 4092, 30, 137, 582.
  - 16k table, IM 0..1: 4074, 439.
  - 40k: standard G.726 table, stored in the package.
- **FILTD:**
  - DIF = ((WI<<5) + 131072 − Y) & 131071.
  - DIFSX = DIF[16] ? (DIF>>5) + 126976 : DIF>>5.
  - YUT = (Y + DIFSX) & 8191.
- **LIMB:** YUP = clamp(YUT, 544, 5120).
- **FILTE:**
  - DIF = (YUP + ((1048576 − YL)>>6)) & 16383.
  - DIFSX = DIF[13] ? DIF + 507904 : DIF.
  - YLP = (YL + DIFSX) & 524287.
- **MIX:**
  - DIF = YU − (YL>>6), treated as sign/magnitude.
  - PROD = (|DIF| × AL) >> 6, truncating toward zero.
  - Y = (YL>>6) ± PROD, using the sign of DIF, masked to 13 bits.
- **Registers:** YU ← YUP and YL ← YLP every cycle; no other state.
- **Reset:** YU = RESET_YU, YL = RESET_YL. Mid-stream reset overrides the update in that cycle.
- **Post-reset outputs:** Y = 544 for any AL, since DIF = 0. YL = 34816.

## Timing
- Y is combinational from the YU/YL registers and AL.
- AL must come from a register in ADAP_SPED_CTL (AP delay); no combinational loop through SUBTC is allowed.
- A code I applied in cycle k affects YU/YL at edge k+1, and Y in cycle k+1.
- YL is a direct register output with 0 extra latency.
- Critical path: AL → 13×7 multiply → Y → FILTD → LIMB → FILTE → YL register. It must close at the system sample clock.
- All arithmetic is modular unsigned at the stated widths; no saturation except LIMB.

## Structure
- **Shared package adpcm_pkg:**
  - WI tables for all four rates.
  - Rate encodings.
  - YU limits 544/5120.
  - Reset constants.
  - Widths 13/19/12.
- **Sub-module scale_mix:** the MIX multiplier/sign stage, reused by the decoder.
- **State:** YU and YL registers use the existing DELAY module (WIDTH 13 and 19, RESET_STATE from parameters).

## Test plan
- **Reset:** assert reset, AL = 0 then AL = 64 → Y = 544, YL = 34816 in both cases.
- **32k step up:** after reset, RATE = 01, I = 4'b0111 for one cycle, AL = 64 → YU = 1649 and YL = 35921 next cycle. Y = 1649 at AL = 64; Y = 561 at AL = 0.
- **Lower clamp:** after reset, RATE = 01, I = 0 (WI = −12) → YUT = 515, YU stays 544. Hold 100 cycles → YU remains 544.
- **Upper clamp:** RATE = 01, I = 7 held 500 cycles → YU = 5120 exactly, never above. YL rises monotonically.
- **Other rates and sign mirror:**
  - RATE = 10, I = 3'b011 after reset → YU = 1109.
  - RATE = 01, I = 4'b1000 gives the same YU as I = 4'b0111.
- **Mid-stream reset:** reset pulsed one cycle during adaptation → next cycle YU = 544, YL = 34816, Y = 544. Adaptation then resumes from those values.
